mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single shared main-memory port behind the instruction and data caches. Accepts one outstanding request at a time from the I-side (read-only) and D-side (read/write) miss engines, arbitrates round-robin on conflict, and drives the stalling memory through issue/wait/respond phases. Returns a one-cycle done pulse with registered read data to the granted requester. Also keeps a saturating conflict counter for the perf log.

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and sequencer for the shared main-memory port (I-side reads, D-side reads/writes).
// Latency: 4 cycles minimum from a request seen in IDLE back to IDLE; +1 per mem_stall cycle in ISSUE and per WAIT cycle without mem_done.
// Backpressure: mem_stall holds the issue phase with all memory outputs frozen; requesters hold req until their done pulse.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   i_req, i_addr         I-side read request (held until i_done) and its address
//   i_done, i_rdata       I-side one-cycle completion pulse; read data held until the next I-side completion
//   d_req, d_wr, d_addr,  D-side request (held until d_done), write/read select, address
//   d_wdata               D-side write data
//   d_done, d_rdata       D-side one-cycle completion pulse; read data updated on reads only
//   mem_en, mem_wr,       memory request valid, write enable (qualified by mem_en),
//   mem_addr, mem_wdata   address and write data from the latched request
//   mem_stall             memory cannot accept the request this cycle
//   mem_done, mem_rdata   memory completion and read data; only honoured in WAIT
//   busy                  arbiter is not idle
//   grant_d               current or most recent grant went to the D-side
//   conflict_cnt          saturating count of IDLE cycles with both requests high

module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_d,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Request as presented to memory; captured once at grant so the
  // requesters' inputs are free to change for the rest of the transaction.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } memReq_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t            state;
  memReq_t           held;
  logic              grantD;
  logic              lastD;
  logic              memEn;
  logic              iDone;
  logic              dDone;
  logic [DATA_W-1:0] iRdata;
  logic [DATA_W-1:0] dRdata;
  logic [15:0]       conflictCnt;

  logic              anyReq;
  logic              bothReq;
  logic              pickD;
  memReq_t           nextReq;

  assign anyReq  = i_req | d_req;
  assign bothReq = i_req & d_req;

  // On a conflict the side that did not win last time goes first. lastD
  // resets to 0, so the very first conflict after reset goes to the D-side.
  always_comb begin
    pickD = d_req;
    if (bothReq) begin
      pickD = ~lastD;
    end
  end

  // I-side is read-only: write flag and write data are forced to zero.
  always_comb begin
    nextReq = '0;
    if (pickD) begin
      nextReq.wr    = d_wr;
      nextReq.addr  = d_addr;
      nextReq.wdata = d_wdata;
    end else begin
      nextReq.addr  = i_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      held        <= '0;
      grantD      <= 1'b0;
      lastD       <= 1'b0;
      memEn       <= 1'b0;
      iDone       <= 1'b0;
      dDone       <= 1'b0;
      iRdata      <= '0;
      dRdata      <= '0;
      conflictCnt <= '0;
    end else begin
      // Done flags live for exactly the one RESP cycle.
      iDone <= 1'b0;
      dDone <= 1'b0;

      case (state)
        IDLE: begin
          if (anyReq) begin
            grantD <= pickD;
            held   <= nextReq;
            memEn  <= 1'b1;
            state  <= ISSUE;
          end
        end

        ISSUE: begin
          // While stalled, nothing changes so memory sees a stable request.
          if (!mem_stall) begin
            memEn <= 1'b0;
            state <= WAIT;
          end
        end

        WAIT: begin
          if (mem_done) begin
            if (!held.wr) begin
              if (grantD) begin
                dRdata <= mem_rdata;
              end else begin
                iRdata <= mem_rdata;
              end
            end
            iDone <= ~grantD;
            dDone <= grantD;
            state <= RESP;
          end
        end

        RESP: begin
          // lastD only moves on completion, so an aborted transaction
          // does not count as a turn.
          lastD <= grantD;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase

      if ((state == IDLE) && bothReq && (conflictCnt != CNT_MAX)) begin
        conflictCnt <= conflictCnt + 16'd1;
      end
    end
  end

  // All outputs come straight from flops or from state/flop decode.
  assign i_done       = iDone;
  assign d_done       = dDone;
  assign i_rdata      = iRdata;
  assign d_rdata      = dRdata;
  assign mem_en       = memEn;
  assign mem_wr       = memEn & held.wr;
  assign mem_addr     = held.addr;
  assign mem_wdata    = held.wdata;
  assign busy         = (state != IDLE);
  assign grant_d      = grantD;
  assign conflict_cnt = conflictCnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a completion scoreboard.
// Latency: stimulus advances one clock per step; expectations are queued at grant time and retired on done pulses.
// Backpressure: the bench plays the memory, inserting stall and wait cycles per vector.
`timescale 1ns/1ps

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_stall;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        grant_d;
  logic [15:0] conflict_cnt;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_done       (i_done),
    .i_rdata      (i_rdata),
    .d_req        (d_req),
    .d_wr         (d_wr),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_done       (d_done),
    .d_rdata      (d_rdata),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_stall    (mem_stall),
    .mem_done     (mem_done),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .grant_d      (grant_d),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        isD;
    logic [15:0] rdata;
  } exp_t;

  exp_t expQ[$];
  int   cmpCnt = 0;
  int   errCnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmpCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic isD, input logic [15:0] rd);
    exp_t e;
    e.isD   = isD;
    e.rdata = rd;
    expQ.push_back(e);
  endtask

  // Monitor: every done pulse retires one queued expectation.
  always @(negedge clk) begin
    if (i_done || d_done) begin
      if (expQ.size() == 0) begin
        cmpCnt++;
        errCnt++;
        $display("FAIL unexpected_done: i_done=%0b d_done=%0b, expected no completion (t=%0t)", i_done, d_done, $time);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("done_side", {i_done, d_done}, e.isD ? 2'b01 : 2'b10);
        if (e.isD) check("d_rdata_at_done", d_rdata, e.rdata);
        else       check("i_rdata_at_done", i_rdata, e.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetChecks(input string tag);
    check({tag, "_busy"},      busy,         0);
    check({tag, "_mem_en"},    mem_en,       0);
    check({tag, "_mem_wr"},    mem_wr,       0);
    check({tag, "_mem_addr"},  mem_addr,     0);
    check({tag, "_mem_wdata"}, mem_wdata,    0);
    check({tag, "_i_done"},    i_done,       0);
    check({tag, "_d_done"},    d_done,       0);
    check({tag, "_i_rdata"},   i_rdata,      0);
    check({tag, "_d_rdata"},   d_rdata,      0);
    check({tag, "_grant_d"},   grant_d,      0);
    check({tag, "_conf_cnt"},  conflict_cnt, 0);
  endtask

  // Plays memory for one transaction. Entered at the start of the first
  // ISSUE cycle; returns at the start of the IDLE cycle after RESP.
  // 'spurious' drives mem_done during ISSUE and RESP, where it must be ignored.
  task automatic memServe(input int stalls, input int waits, input logic [15:0] rd,
                          input logic expWr, input logic [15:0] expAddr,
                          input logic [15:0] expWdata, input logic expD,
                          input logic spurious);
    for (int k = 0; k <= stalls; k++) begin
      mem_stall = (k < stalls);
      mem_done  = spurious;
      mem_rdata = 16'hBAD1;
      @(negedge clk);
      check("issue_mem_en",   mem_en,   1);
      check("issue_mem_wr",   mem_wr,   expWr);
      check("issue_mem_addr", mem_addr, expAddr);
      if (expWr) check("issue_mem_wdata", mem_wdata, expWdata);
      check("issue_grant_d",  grant_d,  expD);
      tick();
    end
    mem_stall = 1'b0;
    mem_done  = 1'b0;
    for (int k = 0; k < waits; k++) begin
      @(negedge clk);
      check("wait_mem_en", mem_en, 0);
      check("wait_busy",   busy,   1);
      tick();
    end
    mem_done  = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    check("wait_mem_en", mem_en, 0);
    tick();
    mem_done  = spurious;
    mem_rdata = 16'hBAD2;
    @(negedge clk);
    check("resp_busy",   busy,   1);
    check("resp_mem_en", mem_en, 0);
    tick();
    mem_done  = 1'b0;
    mem_rdata = 16'hDEAD;
  endtask

  // Both requests held high by the caller; n back-to-back conflicts.
  task automatic conflictRun(input int n, input logic firstD, input logic [15:0] cntStart,
                             input logic [15:0] rdBase, input logic [15:0] iA,
                             input logic [15:0] dA);
    for (int k = 0; k < n; k++) begin
      logic        isD;
      logic [15:0] rd;
      int          c;
      isD = firstD ^ k[0];
      rd  = rdBase + 16'(k);
      c   = int'(cntStart) + k;
      @(negedge clk);
      check("conf_cnt",  conflict_cnt, (c > 32'hFFFF) ? 32'hFFFF : c);
      check("conf_busy", busy, 0);
      push(isD, rd);
      tick();
      memServe(0, 0, rd, 1'b0, isD ? dA : iA, 16'h0, isD, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    mem_stall = 0; mem_done = 0; mem_rdata = 16'hDEAD;
    #1 rst = 1'b0;
    @(negedge clk);
    resetChecks("rst0");
    tick();
    tick();
    rst = 1'b1;

    // I-read 0x0040 -> 0x1234, minimum latency.
    i_req = 1; i_addr = 16'h0040;
    push(1'b0, 16'h1234);
    @(negedge clk);
    check("t1_idle_mem_en", mem_en, 0);
    tick();
    memServe(0, 0, 16'h1234, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0);
    i_req = 0;
    @(negedge clk);
    check("t1_i_rdata",   i_rdata, 16'h1234);
    check("t1_idle_busy", busy,    0);
    check("t1_idle_en",   mem_en,  0);

    // D-read 0x0200 -> 0xA5A5 with two empty WAIT cycles.
    d_req = 1; d_wr = 0; d_addr = 16'h0200; d_wdata = 16'h9999;
    push(1'b1, 16'hA5A5);
    tick();
    memServe(0, 2, 16'hA5A5, 1'b0, 16'h0200, 16'h0, 1'b1, 1'b0);
    d_req = 0;
    @(negedge clk);
    check("tA_d_rdata", d_rdata, 16'hA5A5);
    check("tA_i_rdata", i_rdata, 16'h1234);

    // D-write 0x0100 / 0xBEEF with three stall cycles; d_rdata must hold.
    d_req = 1; d_wr = 1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
    push(1'b1, 16'hA5A5);
    tick();
    memServe(3, 0, 16'h5555, 1'b1, 16'h0100, 16'hBEEF, 1'b1, 1'b0);
    d_req = 0; d_wr = 0;
    @(negedge clk);
    check("t2_d_rdata_held", d_rdata, 16'hA5A5);
    check("t2_mem_wr_idle",  mem_wr,  0);

    // Fresh reset, then both requesters held: D, I, D, I.
    rst = 1'b0;
    @(negedge clk);
    resetChecks("rst1");
    tick();
    rst = 1'b1;
    i_req = 1; i_addr = 16'h0300;
    d_req = 1; d_wr = 0; d_addr = 16'h0400;
    conflictRun(4, 1'b1, 16'h0000, 16'h1111, 16'h0300, 16'h0400);
    i_req = 0; d_req = 0;
    @(negedge clk);
    check("t3_cnt_final", conflict_cnt, 4);
    tick();
    @(negedge clk);
    check("t3_cnt_stable", conflict_cnt, 4);

    // Spurious mem_done in IDLE.
    mem_done = 1; mem_rdata = 16'hBAD0;
    tick();
    @(negedge clk);
    check("t4_idle_busy",    busy,    0);
    check("t4_idle_i_rdata", i_rdata, 16'h1114);
    check("t4_idle_d_rdata", d_rdata, 16'h1113);
    tick();
    mem_done = 0;
    // I-read 0x0500 with mem_done asserted through ISSUE (stalled and not) and RESP.
    i_req = 1; i_addr = 16'h0500;
    push(1'b0, 16'h7777);
    tick();
    memServe(1, 1, 16'h7777, 1'b0, 16'h0500, 16'h0, 1'b0, 1'b1);
    i_req = 0;
    @(negedge clk);
    check("t4_i_rdata", i_rdata, 16'h7777);
    check("t4_d_rdata", d_rdata, 16'h1113);
    check("t4_busy",    busy,    0);

    // Reset during WAIT of a D-read: async clear, no d_done.
    d_req = 1; d_wr = 0; d_addr = 16'h0600;
    tick();
    @(negedge clk);
    check("t5_issue_en", mem_en, 1);
    tick();
    @(negedge clk);
    check("t5_wait_busy", busy, 1);
    #2 rst = 1'b0;
    #1 resetChecks("rst2");
    d_req = 0;
    tick();
    rst = 1'b1;
    i_req = 1; i_addr = 16'h0310;
    d_req = 1; d_addr = 16'h0610;
    conflictRun(1, 1'b1, 16'h0000, 16'h8888, 16'h0310, 16'h0610);
    i_req = 0; d_req = 0;
    @(negedge clk);
    check("t5_d_rdata", d_rdata, 16'h8888);

    // Reset during a stalled ISSUE: mem_en drops without waiting for a clock.
    i_req = 1; i_addr = 16'h0320;
    mem_stall = 1;
    tick();
    @(negedge clk);
    check("t5b_issue_en", mem_en, 1);
    #2 rst = 1'b0;
    #1 check("t5b_async_en", mem_en, 0);
    check("t5b_async_busy", busy, 0);
    i_req = 0; mem_stall = 0;
    tick();
    rst = 1'b1;

    // Saturation: preload the counter near the top, then run conflicts.
    @(negedge clk);
    dut.conflictCnt = 16'hFFFC;
    tick();
    i_req = 1; i_addr = 16'h0330;
    d_req = 1; d_addr = 16'h0630;
    conflictRun(5, 1'b1, 16'hFFFC, 16'h9000, 16'h0330, 16'h0630);
    i_req = 0; d_req = 0;
    @(negedge clk);
    check("t6_cnt_sat", conflict_cnt, 16'hFFFF);
    tick();
    @(negedge clk);
    check("t6_cnt_hold", conflict_cnt, 16'hFFFF);

    repeat (3) tick();
    check("scoreboard_drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
